display_scan_mux: RTL and testbench
===================================

// Module: display_scan_mux
// PURPOSE
//  Time-multiplexes an N-digit common-anode 7-segment display, downstream of the display
//  clock divider. Samples the divider's slow output scan_clk (free-running square wave,
//  ~500 Hz at 100 MHz clk) in the clk domain. Steps one digit per scan_clk rising edge.
//  Decodes the selected hex nibble to segments and inserts an anti-ghosting blank interval.
// PARAMETERS
//  N_DIGITS      4   digits scanned; must be >= 2
//  BLANK_CYCLES  16  clk cycles all anodes are off between digits; 0 is treated as 1
//  SEG_ACT_LOW   1   1: seg/dp_out low = lit; 0: high = lit
//  AN_ACT_LOW    1   1: an low = digit on; 0: high = digit on
// PORTS
//  clk          in   1           system clock; all logic on its rising edge
//  rst          in   1           reset, asynchronous assert, active-low
//  scan_clk     in   1           divided clock from the divider; asynchronous, treated as data
//  en           in   1           1: scan; 0: display dark, scan position frozen
//  value        in   4*N_DIGITS  hex nibbles; [3:0] = digit 0 (rightmost)
//  dp           in   N_DIGITS    decimal point per digit; 1 = lit
//  an           out  N_DIGITS    anode enables, registered
//  seg          out  7           segments {g,f,e,d,c,b,a}, registered
//  dp_out       out  1           decimal point of current digit, registered
//  frame_start  out  1           one-cycle pulse when value/dp are latched (digit 0 start)
// BEHAVIOUR
//  - Reset (rst=0): state=BLANK, idx=0, blank count=0, latched value/dp=0.
//    an, seg and dp_out are all inactive. frame_start=0.
//  - scan_clk sync: s1->s2 two-flop synchronizer plus s3 history; step = s2 & ~s3.
//    The digit advance takes effect on the 3rd clk rising edge after the scan_clk rise.
//  - FSM states: BLANK, SHOW.
//    BLANK: an all inactive; seg/dp_out inactive. Stays max(BLANK_CYCLES,1) cycles,
//      then -> SHOW.
//    SHOW: an = one-hot of idx (polarity per AN_ACT_LOW); seg = decode(latched nibble idx);
//      dp_out = latched dp[idx].
//    SHOW & step: idx <= (idx==N_DIGITS-1) ? 0 : idx+1; -> BLANK; blank counter reloaded.
//  - A step arriving while in BLANK is dropped (no queueing).
//    Integration requires scan period > BLANK_CYCLES+3 clk.
//  - Frame latch: on the SHOW->BLANK transition that wraps idx to 0, value and dp are
//    captured and frame_start=1 for exactly that cycle.
//    Display is tear-free: a frame always shows one coherent value.
//  - en=0: on the next clk the FSM is forced to BLANK with outputs inactive and the counter
//    held at reload. idx and latches are held; steps are ignored.
//    en 0->1: resumes in BLANK, full blank interval, then SHOW with the same idx.
//  - rst asserted mid-digit: outputs go inactive asynchronously, with no glitch to another digit.
//  - Decode: hex 0-F, standard glyphs. Active-high examples: 0=7'h3F, 1=7'h06, 8=7'h7F,
//    A=7'h77, F=7'h71. Active-low is the bitwise inverse.
// CONFIGURATION
//  DISPLAY_LZB_EN (leading-zero blanking):
//   defined: digits above the most significant non-zero latched nibble show seg inactive
//     (anode still scanned; dp still honoured). Digit 0 is never blanked. Computed from the
//     latched value only.
//   undefined: every digit shows its decoded nibble, including leading zeros.
// STRUCTURE
//  - Package disp_pkg: state enum {BLANK, SHOW}; 16-entry SEG_HEX active-high glyph table;
//    SEG_OFF constant.
//  - Sub-module hex_to_seg7 (combinational nibble -> active-high segments, table from
//    disp_pkg). Polarity inversion is applied in display_scan_mux before the output registers.
// TESTING
//  1. Reset: rst=0 with scan_clk toggling -> an=4'hF, seg=7'h7F, dp_out=1 (active-low),
//     frame_start=0 throughout.
//  2. value=16'h1234, dp=4'b0100, scan period 64 clk -> an sequence E,D,B,7 repeating.
//     seg shows 4,3,2,1 inverted glyphs. dp_out=0 only on an=B. Each digit preceded by
//     16 cycles of an=F.
//  3. Change value to 16'hABCD mid-frame -> no digit of ABCD appears until after the next
//     frame_start pulse. Exactly one pulse per 4 steps.
//  4. Step within BLANK (scan period 10 clk, BLANK_CYCLES=16) -> step dropped, idx advances
//     only on steps seen in SHOW, no X/multi-hot an.
//  5. en=0 during digit 2 for 500 cycles -> an=F, idx frozen. On en=1: 16 blank cycles,
//     then digit 2 again.
//  6. DISPLAY_LZB_EN, value=16'h0050 -> digits 3 and 2 dark with anode scanned; digit 1=5,
//     digit 0=0. Without macro: 0,0,5,0 shown.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment display.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package disp_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Index 15 is leftmost in the concatenation.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment glyph.
// Polarity is left to the caller.
module hex_to_seg7
    import disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nib];

endmodule

// File: rtl/display_scan_mux.sv
// N-digit 7-segment scan multiplexer with anti-ghosting blank interval.
// Define DISPLAY_LZB_EN to enable leading-zero blanking.
module display_scan_mux
    import disp_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int BLANK_CYCLES = 16,
    parameter int SEG_ACT_LOW  = 1,
    parameter int AN_ACT_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_clk,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic                  frame_start
);

    localparam int BL = (BLANK_CYCLES < 1) ? 1 : BLANK_CYCLES;
    localparam int CW = (BL > 1) ? $clog2(BL) : 1;
    localparam int IW = $clog2(N_DIGITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(BL - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    localparam logic [6:0] SEG_POL = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_POL  = (SEG_ACT_LOW != 0);
    localparam logic [N_DIGITS-1:0] AN_POL =
        (AN_ACT_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    logic s1, s2, s3;
    logic step;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0] val_q, val_d;
    logic [N_DIGITS-1:0]   dpl_q, dpl_d;
    logic                  fs_d;

    logic [3:0]            nib;
    logic [6:0]            glyph;
    logic                  lz_blank;
    logic [N_DIGITS-1:0]   an_d;
    logic [6:0]            seg_d;
    logic                  dp_d;

    assign step = s2 & ~s3;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        dpl_d   = dpl_q;
        fs_d    = 1'b0;
        if (!en) begin
            state_d = BLANK;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                BLANK: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                SHOW: begin
                    if (step) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            // Latch only on wrap so a frame is never torn
                            idx_d = '0;
                            val_d = value;
                            dpl_d = dp;
                            fs_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with it
    assign nib = val_d[{idx_d, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nib (nib),
        .seg (glyph)
    );

    always_comb begin
`ifdef DISPLAY_LZB_EN
        lz_blank = (idx_d != '0) && ((val_d >> {idx_d, 2'b00}) == '0);
`else
        lz_blank = 1'b0;
`endif
        an_d  = AN_POL;
        seg_d = SEG_POL ^ SEG_OFF;
        dp_d  = DP_POL;
        if (state_d == SHOW) begin
            an_d = AN_POL ^ (N_DIGITS'(1) << idx_d);
            if (!lz_blank) begin
                seg_d = SEG_POL ^ glyph;
            end
            dp_d = DP_POL ^ dpl_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            state_q     <= BLANK;
            idx_q       <= '0;
            cnt_q       <= '0;
            val_q       <= '0;
            dpl_q       <= '0;
            an          <= AN_POL;
            seg         <= SEG_POL ^ SEG_OFF;
            dp_out      <= DP_POL;
            frame_start <= 1'b0;
        end else begin
            s1          <= scan_clk;
            s2          <= s1;
            s3          <= s2;
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            val_q       <= val_d;
            dpl_q       <= dpl_d;
            an          <= an_d;
            seg         <= seg_d;
            dp_out      <= dp_d;
            frame_start <= fs_d;
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed, table-driven bench for display_scan_mux (default parameters).
// Expected glyphs are active-low; DISPLAY_LZB_EN changes the last table.
module tb_display_scan_mux;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
        int         blank;
    } ev_t;

`ifdef DISPLAY_LZB_EN
    localparam logic [6:0] LZ_SEG = 7'h7F;
`else
    localparam logic [6:0] LZ_SEG = 7'h40;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        scan_clk = 1'b0;
    logic        en = 1'b1;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp = 4'b0000;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_out;
    logic        frame_start;

    int   total = 0;
    int   passed = 0;
    int   half = 5;
    bit   scan_on = 1'b0;
    int   sc_cnt = 0;

    ev_t  got[$];
    ev_t  exp_q[$];
    logic [3:0] prev_an = 4'hF;
    logic prev_fs = 1'b0;
    logic fs_pend = 1'b0;
    int   brun = 0;
    int   bad_an = 0;
    int   fs_wide = 0;

    display_scan_mux dut (
        .clk         (clk),
        .rst         (rst),
        .scan_clk    (scan_clk),
        .en          (en),
        .value       (value),
        .dp          (dp),
        .an          (an),
        .seg         (seg),
        .dp_out      (dp_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (scan_on) begin
            if (sc_cnt >= half - 1) begin
                sc_cnt = 0;
                scan_clk = ~scan_clk;
            end else begin
                sc_cnt++;
            end
        end
    end

    // Digit-start recorder and per-cycle sanity checks
    always @(negedge clk) begin
        if (!rst) begin
            prev_an = 4'hF;
            prev_fs = 1'b0;
            fs_pend = 1'b0;
            brun = 0;
        end else begin
            if ($isunknown(an) || !(an == 4'hF || $onehot(~an)))
                bad_an++;
            if (frame_start) begin
                fs_pend = 1'b1;
                if (prev_fs) fs_wide++;
            end
            if (an == 4'hF) begin
                brun++;
            end else begin
                if (an !== prev_an) begin
                    got.push_back('{an, seg, dp_out, fs_pend, brun});
                    fs_pend = 1'b0;
                end
                brun = 0;
            end
            prev_an = an;
            prev_fs = frame_start;
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h", nm, act, req);
    endtask

    task automatic tmo(string nm);
        total++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    task automatic wait_ev(int n, string nm);
        int k = 0;
        while (got.size() < n && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (got.size() < n) tmo(nm);
    endtask

    task automatic wait_fs(string nm);
        int k = 0;
        bit hit = 1'b0;
        while (!hit && k < 5000) begin
            @(negedge clk);
            hit = frame_start;
            k++;
        end
        if (!hit) tmo(nm);
    endtask

    task automatic cmp_tab(string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) begin
                chk($sformatf("%s[%0d].an", tag, i), 32'(got[i].an), 32'(exp_q[i].an));
                chk($sformatf("%s[%0d].seg", tag, i), 32'(got[i].seg), 32'(exp_q[i].seg));
                chk($sformatf("%s[%0d].dp", tag, i), 32'(got[i].dp), 32'(exp_q[i].dp));
                chk($sformatf("%s[%0d].fs", tag, i), 32'(got[i].fs), 32'(exp_q[i].fs));
                chk($sformatf("%s[%0d].blank", tag, i), got[i].blank, exp_q[i].blank);
            end else begin
                total++;
                $display("FAIL %s[%0d]: missing event, got %0d required %0d",
                         tag, i, got.size(), exp_q.size());
            end
        end
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int lit;

        // Reset held while scan_clk toggles
        scan_on = 1'b1;
        half = 5;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst.an", 32'(an), 32'hF);
            chk("rst.seg", 32'(seg), 32'h7F);
            chk("rst.dp", 32'(dp_out), 32'h1);
            chk("rst.fs", 32'(frame_start), 32'h0);
        end

        // Normal scan of 1234
        @(posedge clk); #1;
        value = 16'h1234;
        dp = 4'b0100;
        half = 32;
        rst = 1'b1;
        wait_fs("t2.fs");
        got.delete();
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back('{4'hE, 7'h19, 1'b1, 1'b1, 16});
            exp_q.push_back('{4'hD, 7'h30, 1'b1, 1'b0, 16});
            exp_q.push_back('{4'hB, 7'h24, 1'b0, 1'b0, 16});
            exp_q.push_back('{4'h7, 7'h79, 1'b1, 1'b0, 16});
        end
        wait_ev(8, "t2.ev");
        cmp_tab("t2");

        // Value change mid-frame must wait for the next frame
        got.delete();
        wait_ev(2, "t3.pre");
        value = 16'hABCD;
        got.delete();
        exp_q.push_back('{4'hB, 7'h24, 1'b0, 1'b0, 16});
        exp_q.push_back('{4'h7, 7'h79, 1'b1, 1'b0, 16});
        exp_q.push_back('{4'hE, 7'h21, 1'b1, 1'b1, 16});
        exp_q.push_back('{4'hD, 7'h46, 1'b1, 1'b0, 16});
        exp_q.push_back('{4'hB, 7'h03, 1'b0, 1'b0, 16});
        exp_q.push_back('{4'h7, 7'h08, 1'b1, 1'b0, 16});
        wait_ev(6, "t3.ev");
        cmp_tab("t3");

        // Fast scan: steps landing in BLANK are dropped
        half = 5;
        got.delete();
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back('{4'hE, 7'h21, 1'b1, 1'b1, 16});
            exp_q.push_back('{4'hD, 7'h46, 1'b1, 1'b0, 16});
            exp_q.push_back('{4'hB, 7'h03, 1'b0, 1'b0, 16});
            exp_q.push_back('{4'h7, 7'h08, 1'b1, 1'b0, 16});
        end
        wait_ev(8, "t4.ev");
        cmp_tab("t4");

        // en=0 during digit 2
        half = 32;
        n = 0;
        while (an !== 4'hB && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (an !== 4'hB) tmo("t5.digit2");
        @(posedge clk); #1;
        en = 1'b0;
        got.delete();
        @(negedge clk);
        @(negedge clk);
        chk("t5.dark", 32'(an), 32'hF);
        lit = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (an !== 4'hF || seg !== 7'h7F) lit++;
        end
        chk("t5.lit_while_off", lit, 0);
        chk("t5.events_while_off", got.size(), 0);
        @(posedge clk); #1;
        en = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (an !== 4'hF) break;
            n++;
        end
        chk("t5.resume_blank", n, 16);
        chk("t5.resume_an", 32'(an), 32'hB);

        // Leading zeros on 0050 with dp on digit 3
        value = 16'h0050;
        dp = 4'b1000;
        wait_fs("t6.fs");
        got.delete();
        exp_q.push_back('{4'hE, 7'h40, 1'b1, 1'b1, 16});
        exp_q.push_back('{4'hD, 7'h12, 1'b1, 1'b0, 16});
        exp_q.push_back('{4'hB, LZ_SEG, 1'b1, 1'b0, 16});
        exp_q.push_back('{4'h7, LZ_SEG, 1'b0, 1'b0, 16});
        wait_ev(4, "t6.ev");
        cmp_tab("t6");

        chk("an_onehot_or_off", bad_an, 0);
        chk("fs_single_cycle", fs_wide, 0);

        // Async reset in the middle of a lit digit
        n = 0;
        while (an === 4'hF && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (an === 4'hF) tmo("rst_async.lit");
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async.an", 32'(an), 32'hF);
        chk("rst_async.seg", 32'(seg), 32'h7F);
        chk("rst_async.dp", 32'(dp_out), 32'h1);
        chk("rst_async.fs", 32'(frame_start), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
